usbdev_in_ep_ctrl: RTL and testbench
====================================

Name: usbdev_in_ep_ctrl

Overview:
Per-endpoint IN packet scheduler between the software register interface, the packet buffer memory and the non-buffered IN protocol engine.
- Holds a configured buffer (ID, size) per IN endpoint.
- Answers the engine's has_data/data_done queries and fetches payload bytes from buffer memory.
- Retires the buffer on ACK, keeps it on rollback, and cancels it on SETUP or link reset.

Parameters:
NumInEps, 12, number of implemented IN endpoints (1..16)
MaxPktSizeByte, 64, max packet payload; PktW = $clog2(MaxPktSizeByte)
NumBuffers, 32, packet buffers in memory; BufW = $clog2(NumBuffers)
MemAw, BufW+PktW-2, word address width of 32-bit buffer memory

Ports:
clk_48mhz_i  in  1  sole clock
rst_ni  in  1  asynchronous active-low reset
link_reset_i  in  1  bus reset; cancels all queued packets
cfg_we_i  in  1  software write strobe for one endpoint config
cfg_ep_i  in  4  endpoint being written
cfg_buf_i  in  BufW  buffer ID
cfg_size_i  in  PktW+1  payload bytes, 0..MaxPktSizeByte
cfg_rdy_i  in  1  mark packet ready (0 = software cancel)
in_xact_starting_i  in  1  engine: IN transaction starting
in_xact_start_ep_i  in  4  endpoint of starting transaction
in_ep_current_i  in  4  engine's current endpoint
in_ep_get_addr_i  in  PktW  byte offset requested
in_ep_data_get_i  in  1  byte consumed
in_ep_xact_end_i  in  1  good completion (ACK, or ISO with data)
in_ep_rollback_i  in  1  bad termination
setup_ep_i  in  NumInEps  one-hot SETUP token seen on endpoint
in_ep_has_data_o  out  NumInEps  rdy bit per endpoint
in_ep_data_done_o  out  NumInEps  payload exhausted, current endpoint only
in_ep_data_o  out  8  byte at in_ep_get_addr_i
mem_req_o  out  1  buffer memory read request
mem_addr_o  out  MemAw  word address {buf, get_addr[PktW-1:2]}
mem_rdata_i  in  32  read data, valid 1 cycle after mem_req_o
rdy_o  out  NumInEps  readback of rdy bits
busy_o  out  NumInEps  endpoint mid-transaction
pkt_sent_o  out  NumInEps  1-cycle pulse per retired packet
cancelled_o  out  NumInEps  1-cycle pulse when a ready packet is dropped

Behaviour:
- Reset values: all outputs, config storage and per-EP state are 0 / EpIdle. mem_addr_o is 0.
- Per-EP FSM, one per endpoint:
  - EpIdle → EpReady: cfg_we_i with cfg_rdy_i=1.
  - EpReady → EpBusy: in_xact_starting_i for this EP.
  - EpBusy → EpIdle on in_ep_xact_end_i: clear rdy, pulse pkt_sent_o.
  - EpBusy → EpReady on in_ep_rollback_i.
- Config writes:
  - Allowed in EpIdle and EpReady.
  - A write while EpBusy is ignored entirely; buffer and size stay stable for the in-flight transaction.
  - cfg_rdy_i=0 while EpReady → EpIdle with a cancelled_o pulse.
- Cancellation: setup_ep_i[n], or link_reset_i on all EPs, forces EpIdle from any state. cancelled_o pulses only where rdy was 1. This priority is above xact_end/rollback in the same cycle.
- Simultaneous xact_end and new cfg_we_i to the same EP in one cycle: xact_end wins and the write is dropped.
- cfg_ep_i >= NumInEps: write ignored.
- in_ep_has_data_o = rdy bits, combinational from registers.
- in_ep_data_done_o[cur] = ({1'b0,get_addr} >= size[cur]), other bits 0. Size 0 gives done immediately, i.e. a zero-length packet.
- Memory read:
  - mem_req_o=1 while the current EP is busy.
  - mem_addr_o is combinational from the current buffer and get_addr.
  - in_ep_data_o = byte lane get_addr_q[1:0] of mem_rdata_i, where get_addr_q is get_addr registered once, so latency is 1 cycle.
- Get address at MaxPktSizeByte-1 with a data get: word index wraps to 0, with no side effect; the engine terminates the packet.

Optional Feature:
USBDEV_IN_SENT_CNT_EN
- With it: adds output sent_cnt_o [NumInEps*8].
  - Per-EP 8-bit counter, +1 on each pkt_sent pulse, saturating at 255.
  - Cleared on reset, on link_reset_i, and by a cfg write with cfg_size_i all ones.
- Without it: the output and counters are absent.

Decomposition:
- usbdev_pkg holds:
  - in_ep_state_e (EpIdle, EpReady, EpBusy);
  - the in_ep_cfg_t struct {buf, size, rdy};
  - the MaxPktSizeByte constant.
- Sub-module usbdev_in_ep_slot implements one endpoint's FSM and config storage. It is instanced NumInEps times by generate.
- The byte-lane mux and memory addressing stay in the top module.

Test Plan:
- Ready, then ACK:
  - Setup: cfg EP2 buf=5 size=3 rdy, then start EP2; engine gets 3 bytes, then xact_end.
  - Expect: has_data[2]=1 until end, mem_addr_o={5,0}, data bytes = lanes 0,1,2, done at addr 3, pkt_sent_o[2] one pulse, rdy[2]=0.
- Rollback:
  - Setup: as above, but in_ep_rollback_i instead of xact_end.
  - Expect: EP2 back in EpReady, rdy[2]=1, no pkt_sent; a retry sends the same bytes.
- Zero-length packet:
  - Setup: size=0, then start.
  - Expect: data_done[cur]=1 in the first cycle; xact_end gives pkt_sent pulse.
- SETUP cancel:
  - Setup: EP0 busy, setup_ep_i[0]=1 and in_ep_xact_end_i=1 in the same cycle.
  - Expect: EP0 goes EpIdle, cancelled_o[0] pulses, pkt_sent_o[0] stays 0.
- Write while busy and illegal EP:
  - Setup: cfg_we_i to a busy EP with buf=9; cfg_ep_i=13 with NumInEps=12.
  - Expect: stored buf unchanged, no state change anywhere.
- Reset mid-packet:
  - Setup: assert rst_ni low while EP1 is busy at addr 20.
  - Expect: all outputs 0, all EPs EpIdle, mem_req_o=0 asynchronously.

Source files
------------

// File: rtl/usbdev_pkg.sv
// Shared types and sizing for the USB device IN endpoint scheduler.
package usbdev_pkg;

    localparam int MaxPktSizeByte = 64;
    localparam int PktW           = $clog2(MaxPktSizeByte);
    localparam int NumBuffers     = 32;
    localparam int BufW           = $clog2(NumBuffers);
    localparam int MemAw          = BufW + PktW - 2;

    typedef enum logic [1:0] {
        EpIdle,
        EpReady,
        EpBusy
    } in_ep_state_e;

    // buf is a reserved gate keyword, hence buf_id
    typedef struct packed {
        logic [BufW-1:0] buf_id;
        logic [PktW:0]   size;
        logic            rdy;
    } in_ep_cfg_t;

endpackage

// File: rtl/usbdev_in_ep_slot.sv
// One IN endpoint: packet FSM plus buffer/size storage.
// Optional per-endpoint sent counter under USBDEV_IN_SENT_CNT_EN.
module usbdev_in_ep_slot
    import usbdev_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            link_reset_i,
    input  logic            setup_i,
    input  logic            cfg_we_i,
    input  logic [BufW-1:0] cfg_buf_i,
    input  logic [PktW:0]   cfg_size_i,
    input  logic            cfg_rdy_i,
    input  logic            start_i,
    input  logic            xact_end_i,
    input  logic            rollback_i,
    output in_ep_cfg_t      cfg_o,
    output logic            busy_o,
    output logic            pkt_sent_o,
    output logic            cancelled_o
`ifdef USBDEV_IN_SENT_CNT_EN
   ,output logic [7:0]      sent_cnt_o
`endif
);

    in_ep_state_e state_q, state_d;
    in_ep_cfg_t   cfg_q, cfg_d, cfg_wr;
    logic         pkt_sent_q, pkt_sent_d;
    logic         cancelled_q, cancelled_d;

    assign cfg_wr = '{buf_id: cfg_buf_i, size: cfg_size_i, rdy: cfg_rdy_i};

    // Cancellation outranks everything; config writes are frozen while busy.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        pkt_sent_d  = 1'b0;
        cancelled_d = 1'b0;
        if (setup_i || link_reset_i) begin
            state_d     = EpIdle;
            cfg_d.rdy   = 1'b0;
            cancelled_d = cfg_q.rdy;
        end else begin
            case (state_q)
                EpIdle: begin
                    if (cfg_we_i) begin
                        cfg_d = cfg_wr;
                        if (cfg_rdy_i) state_d = EpReady;
                    end
                end
                EpReady: begin
                    if (cfg_we_i) cfg_d = cfg_wr;
                    if (cfg_we_i && !cfg_rdy_i) begin
                        state_d     = EpIdle;
                        cancelled_d = 1'b1;
                    end else if (start_i) begin
                        state_d = EpBusy;
                    end
                end
                EpBusy: begin
                    if (xact_end_i) begin
                        state_d    = EpIdle;
                        cfg_d.rdy  = 1'b0;
                        pkt_sent_d = 1'b1;
                    end else if (rollback_i) begin
                        state_d = EpReady;
                    end
                end
                default: state_d = EpIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EpIdle;
            cfg_q       <= '0;
            pkt_sent_q  <= 1'b0;
            cancelled_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            pkt_sent_q  <= pkt_sent_d;
            cancelled_q <= cancelled_d;
        end
    end

    assign cfg_o       = cfg_q;
    assign busy_o      = (state_q == EpBusy);
    assign pkt_sent_o  = pkt_sent_q;
    assign cancelled_o = cancelled_q;

`ifdef USBDEV_IN_SENT_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // A write with an all-ones size is the software clear for the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (link_reset_i || (cfg_we_i && (&cfg_size_i))) begin
            cnt_d = '0;
        end else if (pkt_sent_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sent_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/usbdev_in_ep_ctrl.sv
// IN packet scheduler: per-endpoint slots, buffer memory addressing and byte-lane mux.
// Optional sent counters enabled by USBDEV_IN_SENT_CNT_EN.
module usbdev_in_ep_ctrl
    import usbdev_pkg::*;
#(
    parameter int NumInEps = 12
) (
    input  logic                  clk_48mhz_i,
    input  logic                  rst_ni,
    input  logic                  link_reset_i,
    input  logic                  cfg_we_i,
    input  logic [3:0]            cfg_ep_i,
    input  logic [BufW-1:0]       cfg_buf_i,
    input  logic [PktW:0]         cfg_size_i,
    input  logic                  cfg_rdy_i,
    input  logic                  in_xact_starting_i,
    input  logic [3:0]            in_xact_start_ep_i,
    input  logic [3:0]            in_ep_current_i,
    input  logic [PktW-1:0]       in_ep_get_addr_i,
    input  logic                  in_ep_data_get_i,
    input  logic                  in_ep_xact_end_i,
    input  logic                  in_ep_rollback_i,
    input  logic [NumInEps-1:0]   setup_ep_i,
    output logic [NumInEps-1:0]   in_ep_has_data_o,
    output logic [NumInEps-1:0]   in_ep_data_done_o,
    output logic [7:0]            in_ep_data_o,
    output logic                  mem_req_o,
    output logic [MemAw-1:0]      mem_addr_o,
    input  logic [31:0]           mem_rdata_i,
    output logic [NumInEps-1:0]   rdy_o,
    output logic [NumInEps-1:0]   busy_o,
    output logic [NumInEps-1:0]   pkt_sent_o,
    output logic [NumInEps-1:0]   cancelled_o
`ifdef USBDEV_IN_SENT_CNT_EN
   ,output logic [NumInEps*8-1:0] sent_cnt_o
`endif
);

    in_ep_cfg_t            ep_cfg [NumInEps];
    logic [NumInEps-1:0]   rdy, busy, cur_sel;
    logic [BufW-1:0]       cur_buf;
    logic [PktW:0]         cur_size;
    logic                  cur_busy;
    logic [1:0]            lane_q;
    logic                  req_q;

    // Byte pacing is carried entirely by get_addr, so the consume strobe is not needed.
    logic unused_data_get;
    assign unused_data_get = in_ep_data_get_i;

    always_comb begin
        cur_sel = '0;
        for (int i = 0; i < NumInEps; i++) begin
            cur_sel[i] = (in_ep_current_i == 4'(i));
        end
    end

    for (genvar n = 0; n < NumInEps; n++) begin : g_slot
        usbdev_in_ep_slot u_slot (
            .clk_i        (clk_48mhz_i),
            .rst_ni       (rst_ni),
            .link_reset_i (link_reset_i),
            .setup_i      (setup_ep_i[n]),
            .cfg_we_i     (cfg_we_i && (cfg_ep_i == 4'(n))),
            .cfg_buf_i    (cfg_buf_i),
            .cfg_size_i   (cfg_size_i),
            .cfg_rdy_i    (cfg_rdy_i),
            .start_i      (in_xact_starting_i && (in_xact_start_ep_i == 4'(n))),
            .xact_end_i   (in_ep_xact_end_i && cur_sel[n]),
            .rollback_i   (in_ep_rollback_i && cur_sel[n]),
            .cfg_o        (ep_cfg[n]),
            .busy_o       (busy[n]),
            .pkt_sent_o   (pkt_sent_o[n]),
            .cancelled_o  (cancelled_o[n])
`ifdef USBDEV_IN_SENT_CNT_EN
           ,.sent_cnt_o   (sent_cnt_o[n*8 +: 8])
`endif
        );
        assign rdy[n] = ep_cfg[n].rdy;
    end

    // An out-of-range current endpoint selects nothing and reads as idle.
    always_comb begin
        cur_buf  = '0;
        cur_size = '0;
        cur_busy = 1'b0;
        for (int i = 0; i < NumInEps; i++) begin
            if (cur_sel[i]) begin
                cur_buf  = ep_cfg[i].buf_id;
                cur_size = ep_cfg[i].size;
                cur_busy = busy[i];
            end
        end
    end

    assign mem_req_o         = cur_busy;
    assign mem_addr_o        = cur_busy ? {cur_buf, in_ep_get_addr_i[PktW-1:2]} : '0;
    assign in_ep_data_done_o = cur_sel & {NumInEps{cur_busy && ({1'b0, in_ep_get_addr_i} >= cur_size)}};

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            req_q  <= 1'b0;
        end else begin
            lane_q <= in_ep_get_addr_i[1:0];
            req_q  <= mem_req_o;
        end
    end

    assign in_ep_data_o     = req_q ? mem_rdata_i[{lane_q, 3'b000} +: 8] : 8'h00;
    assign in_ep_has_data_o = rdy;
    assign rdy_o            = rdy;
    assign busy_o           = busy;

endmodule

// File: tb/tb_usbdev_in_ep_ctrl.sv
// Directed table-driven bench for usbdev_in_ep_ctrl with hand sequences for cancel/reset corners.
module tb_usbdev_in_ep_ctrl;

    localparam int NEp = 12;

    typedef struct {
        logic        we;
        logic [3:0]  ep;
        logic [4:0]  bf;
        logic [6:0]  sz;
        logic        rd;
        logic        st;
        logic [3:0]  sep;
        logic [3:0]  cur;
        logic [5:0]  ad;
        logic        xe;
        logic        rb;
        logic [11:0] eRdy;
        logic [11:0] eBusy;
        logic [11:0] eSent;
        logic [11:0] eCanc;
        logic [11:0] eDone;
        logic        eReq;
        logic [8:0]  eAddr;
        logic        chk;
        logic [7:0]  eData;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            link_reset;
    logic            cfg_we;
    logic [3:0]      cfg_ep;
    logic [4:0]      cfg_buf;
    logic [6:0]      cfg_size;
    logic            cfg_rdy;
    logic            starting;
    logic [3:0]      start_ep;
    logic [3:0]      cur_ep;
    logic [5:0]      get_addr;
    logic            data_get;
    logic            xact_end;
    logic            rollback;
    logic [NEp-1:0]  setup_ep;
    logic [NEp-1:0]  has_data, data_done, rdy, busy, pkt_sent, cancelled;
    logic [7:0]      data;
    logic            mem_req;
    logic [8:0]      mem_addr;
    logic [31:0]     mem_rdata;
`ifdef USBDEV_IN_SENT_CNT_EN
    logic [NEp*8-1:0] sent_cnt;
`endif

    logic [31:0] memw [512];
    int          errors = 0;
    int          checks = 0;
    vec_t        vq [$];

    usbdev_in_ep_ctrl #(.NumInEps(NEp)) dut (
        .clk_48mhz_i        (clk),
        .rst_ni             (rst_n),
        .link_reset_i       (link_reset),
        .cfg_we_i           (cfg_we),
        .cfg_ep_i           (cfg_ep),
        .cfg_buf_i          (cfg_buf),
        .cfg_size_i         (cfg_size),
        .cfg_rdy_i          (cfg_rdy),
        .in_xact_starting_i (starting),
        .in_xact_start_ep_i (start_ep),
        .in_ep_current_i    (cur_ep),
        .in_ep_get_addr_i   (get_addr),
        .in_ep_data_get_i   (data_get),
        .in_ep_xact_end_i   (xact_end),
        .in_ep_rollback_i   (rollback),
        .setup_ep_i         (setup_ep),
        .in_ep_has_data_o   (has_data),
        .in_ep_data_done_o  (data_done),
        .in_ep_data_o       (data),
        .mem_req_o          (mem_req),
        .mem_addr_o         (mem_addr),
        .mem_rdata_i        (mem_rdata),
        .rdy_o              (rdy),
        .busy_o             (busy),
        .pkt_sent_o         (pkt_sent),
        .cancelled_o        (cancelled)
`ifdef USBDEV_IN_SENT_CNT_EN
       ,.sent_cnt_o         (sent_cnt)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Byte content is a scramble of the absolute byte position buf*64+offset.
    function automatic logic [7:0] mix(input int x);
        return 8'((x * 7) ^ 32'h5A);
    endfunction

    function automatic logic [7:0] expByte(input int b, input int off);
        return mix(b * 64 + off);
    endfunction

    initial begin
        for (int w = 0; w < 512; w++) begin
            for (int l = 0; l < 4; l++) begin
                memw[w][8*l +: 8] = mix(w * 4 + l);
            end
        end
    end

    always @(posedge clk) begin
        if (mem_req) mem_rdata <= memw[mem_addr];
    end

    function automatic vec_t mkv(input int we, ep, bf, sz, rd, st, sep, cur, ad, xe, rb,
                                 input int eRdy, eBusy, eSent, eCanc, eDone, eReq, eAddr,
                                 input int chk, eData);
        vec_t v;
        v.we = 1'(we);      v.ep = 4'(ep);       v.bf = 5'(bf);      v.sz = 7'(sz);
        v.rd = 1'(rd);      v.st = 1'(st);       v.sep = 4'(sep);    v.cur = 4'(cur);
        v.ad = 6'(ad);      v.xe = 1'(xe);       v.rb = 1'(rb);
        v.eRdy = 12'(eRdy); v.eBusy = 12'(eBusy); v.eSent = 12'(eSent);
        v.eCanc = 12'(eCanc); v.eDone = 12'(eDone); v.eReq = 1'(eReq);
        v.eAddr = 9'(eAddr); v.chk = 1'(chk);    v.eData = 8'(eData);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        cfg_we   = v.we;  cfg_ep   = v.ep;  cfg_buf  = v.bf;  cfg_size = v.sz;
        cfg_rdy  = v.rd;  starting = v.st;  start_ep = v.sep; cur_ep   = v.cur;
        get_addr = v.ad;  data_get = v.chk; xact_end = v.xe;  rollback = v.rb;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkVec(input string tag, input vec_t v);
        checkOutput({tag, ".has_data"}, 32'(has_data), 32'(v.eRdy));
        checkOutput({tag, ".rdy"}, 32'(rdy), 32'(v.eRdy));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(v.eBusy));
        checkOutput({tag, ".pkt_sent"}, 32'(pkt_sent), 32'(v.eSent));
        checkOutput({tag, ".cancelled"}, 32'(cancelled), 32'(v.eCanc));
        checkOutput({tag, ".done"}, 32'(data_done), 32'(v.eDone));
        checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'(v.eReq));
        checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.eAddr));
        if (v.chk) checkOutput({tag, ".data"}, 32'(data), 32'(v.eData));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".has_data"}, 32'(has_data), 0);
        checkOutput({tag, ".rdy"}, 32'(rdy), 0);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
        checkOutput({tag, ".done"}, 32'(data_done), 0);
        checkOutput({tag, ".pkt_sent"}, 32'(pkt_sent), 0);
        checkOutput({tag, ".cancelled"}, 32'(cancelled), 0);
        checkOutput({tag, ".mem_req"}, 32'(mem_req), 0);
        checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 0);
        checkOutput({tag, ".data"}, 32'(data), 0);
    endtask

    initial begin
        rst_n = 1'b0; link_reset = 1'b0; setup_ep = '0;
        cfg_we = 0; cfg_ep = 0; cfg_buf = 0; cfg_size = 0; cfg_rdy = 0;
        starting = 0; start_ep = 0; cur_ep = 0; get_addr = 0; data_get = 0;
        xact_end = 0; rollback = 0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fields: we ep buf size rdy | start sep | cur addr xend rb | eRdy eBusy eSent eCanc eDone | eReq eAddr | chk eData
        // Ready then ACK on EP2, buf 5, 3 bytes
        vq.push_back(mkv(1,2,5,3,1, 0,0, 2,0,0,0, 'h004,0,0,0,0, 0,0, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 1,2, 2,0,0,0, 'h004,'h004,0,0,0, 1,'h050, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,0,0,0, 'h004,'h004,0,0,0, 1,'h050, 1,expByte(5,0)));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,1,0,0, 'h004,'h004,0,0,0, 1,'h050, 1,expByte(5,1)));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,2,0,0, 'h004,'h004,0,0,0, 1,'h050, 1,expByte(5,2)));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,3,0,0, 'h004,'h004,0,0,'h004, 1,'h050, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,3,1,0, 0,0,'h004,0,0, 0,0, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        // Rollback then retry
        vq.push_back(mkv(1,2,5,3,1, 0,0, 2,0,0,0, 'h004,0,0,0,0, 0,0, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 1,2, 2,0,0,0, 'h004,'h004,0,0,0, 1,'h050, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,1,0,0, 'h004,'h004,0,0,0, 1,'h050, 1,expByte(5,1)));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,1,0,1, 'h004,0,0,0,0, 0,0, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 1,2, 2,0,0,0, 'h004,'h004,0,0,0, 1,'h050, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,0,0,0, 'h004,'h004,0,0,0, 1,'h050, 1,expByte(5,0)));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,2,0,0, 'h004,'h004,0,0,0, 1,'h050, 1,expByte(5,2)));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 2,2,1,0, 0,0,'h004,0,0, 0,0, 0,0));
        // Zero-length packet on EP7, buf 9
        vq.push_back(mkv(1,7,9,0,1, 0,0, 7,0,0,0, 'h080,0,0,0,0, 0,0, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 1,7, 7,0,0,0, 'h080,'h080,0,0,'h080, 1,'h090, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 7,0,1,0, 0,0,'h080,0,0, 0,0, 0,0));
        // Write while busy, illegal EP, out-of-range current EP, xact_end beats a write
        vq.push_back(mkv(1,3,1,4,1, 0,0, 3,0,0,0, 'h008,0,0,0,0, 0,0, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 1,3, 3,0,0,0, 'h008,'h008,0,0,0, 1,'h010, 0,0));
        vq.push_back(mkv(1,3,9,2,0, 0,0, 3,0,0,0, 'h008,'h008,0,0,0, 1,'h010, 0,0));
        vq.push_back(mkv(1,13,2,5,1, 0,0, 3,4,0,0, 'h008,'h008,0,0,'h008, 1,'h011, 1,expByte(1,4)));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 13,0,0,0, 'h008,'h008,0,0,0, 0,0, 1,0));
        vq.push_back(mkv(1,3,4,2,1, 0,0, 3,0,1,0, 0,0,'h008,0,0, 0,0, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 3,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        // Software cancel of a ready packet
        vq.push_back(mkv(1,4,2,8,1, 0,0, 4,0,0,0, 'h010,0,0,0,0, 0,0, 0,0));
        vq.push_back(mkv(1,4,2,8,0, 0,0, 4,0,0,0, 0,0,0,'h010,0, 0,0, 0,0));
        vq.push_back(mkv(0,0,0,0,0, 0,0, 4,0,0,0, 0,0,0,0,0, 0,0, 0,0));

        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i]);
            checkVec($sformatf("v%0d", i), vq[i]);
        end

        // SETUP and xact_end together on busy EP0: cancel wins, no pkt_sent
        applyStimulus(mkv(1,0,3,10,1, 0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        applyStimulus(mkv(0,0,0,0,0, 1,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        checkOutput("setup.busy_before", 32'(busy), 32'h001);
        setup_ep = 12'h001;
        applyStimulus(mkv(0,0,0,0,0, 0,0, 0,0,1,0, 0,0,0,0,0, 0,0, 0,0));
        setup_ep = '0;
        checkOutput("setup.cancelled", 32'(cancelled), 32'h001);
        checkOutput("setup.pkt_sent", 32'(pkt_sent), 0);
        checkOutput("setup.busy", 32'(busy), 0);
        checkOutput("setup.rdy", 32'(rdy), 0);
        applyStimulus(mkv(0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        checkOutput("setup.pulse_end", 32'(cancelled), 0);
        checkOutput("setup.no_late_sent", 32'(pkt_sent), 0);
        setup_ep = 12'h020;
        applyStimulus(mkv(0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        setup_ep = '0;
        checkOutput("setup.idle_ep_no_cancel", 32'(cancelled), 0);

        // Link reset drops every ready packet
        applyStimulus(mkv(1,1,6,8,1, 0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        applyStimulus(mkv(1,6,7,8,1, 0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        checkOutput("linkrst.rdy_before", 32'(rdy), 32'h042);
        link_reset = 1'b1;
        applyStimulus(mkv(0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        link_reset = 1'b0;
        checkOutput("linkrst.cancelled", 32'(cancelled), 32'h042);
        checkOutput("linkrst.rdy", 32'(rdy), 0);

        // Asynchronous reset while EP1 is busy at byte 20
        applyStimulus(mkv(1,1,2,40,1, 0,0, 1,0,0,0, 0,0,0,0,0, 0,0, 0,0));
        applyStimulus(mkv(0,0,0,0,0, 1,1, 1,20,0,0, 0,0,0,0,0, 0,0, 0,0));
        applyStimulus(mkv(0,0,0,0,0, 0,0, 1,20,0,0, 0,0,0,0,0, 0,0, 1,0));
        checkOutput("arst.busy_before", 32'(busy), 32'h002);
        checkOutput("arst.mem_addr_before", 32'(mem_addr), 32'h025);
        checkOutput("arst.data_before", 32'(data), 32'(expByte(2, 20)));
        #3;
        rst_n = 1'b0;
        #3;
        checkAllZero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkv(0,0,0,0,0, 0,0, 1,20,0,0, 0,0,0,0,0, 0,0, 0,0));
        checkAllZero("arst.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
